// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: tracks start/data/parity/stop phases, validates each frame
// and reports a data-valid pulse, held error flags and a saturating errored-frame count.
module uart_rx_ctrl #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX_IN,
  input  logic                 PAR_EN,
  input  logic                 PAR_TYP,
  input  logic                 edge_cnt_done,
  input  logic                 bit_cnt_done,
  input  logic                 sampled_bit,
  output logic                 counter_en,
  output logic                 deser_en,
  output logic                 busy,
  output logic                 data_valid,
  output logic                 par_err,
  output logic                 stp_err,
  output logic                 strt_glitch,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  state_e               r_state;
  logic                 r_par_en;
  logic                 r_par_typ;
  logic                 r_acc;
  logic                 r_data_valid;
  logic                 r_par_err;
  logic                 r_stp_err;
  logic                 r_strt_glitch;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state       <= StIdle;
      r_par_en      <= 1'b0;
      r_par_typ     <= 1'b0;
      r_acc         <= 1'b0;
      r_data_valid  <= 1'b0;
      r_par_err     <= 1'b0;
      r_stp_err     <= 1'b0;
      r_strt_glitch <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_data_valid  <= 1'b0;
      r_strt_glitch <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // Frame settings are captured here so mid-frame input changes cannot leak in
          if (!RX_IN) begin
            r_state   <= StStart;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_acc     <= 1'b0;
            r_par_err <= 1'b0;
            r_stp_err <= 1'b0;
          end
        end
        StStart: begin
          if (edge_cnt_done) begin
            if (sampled_bit) begin
              r_strt_glitch <= 1'b1;
              r_state       <= StIdle;
            end else begin
              r_state <= StData;
            end
          end
        end
        StData: begin
          if (edge_cnt_done) begin
            r_acc <= r_acc ^ sampled_bit;
            if (bit_cnt_done) r_state <= r_par_en ? StParity : StStop;
          end
        end
        StParity: begin
          if (edge_cnt_done) begin
            r_par_err <= (sampled_bit != (r_acc ^ r_par_typ));
            r_state   <= StStop;
          end
        end
        StStop: begin
          if (edge_cnt_done) begin
            r_stp_err <= ~sampled_bit;
            r_state   <= StIdle;
            // A frame with both errors still counts only once
            if (!r_par_err && sampled_bit) begin
              r_data_valid <= 1'b1;
            end else if (r_err_cnt != {ERR_CNT_W{1'b1}}) begin
              r_err_cnt <= r_err_cnt + 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy        = (r_state != StIdle);
  assign counter_en  = (r_state != StIdle);
  assign deser_en    = (r_state == StData);
  assign data_valid  = r_data_valid;
  assign par_err     = r_par_err;
  assign stp_err     = r_stp_err;
  assign strt_glitch = r_strt_glitch;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized frame-level bench for uart_rx_ctrl with ideal edge/bit counters and sampler.
module tb_uart_rx_ctrl;
  localparam int P = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       edge_cnt_done, bit_cnt_done, sampled_bit;
  logic       counter_en, deser_en, busy, data_valid, par_err, stp_err, strt_glitch;
  logic [7:0] err_cnt;
  logic       counter_en2, deser_en2, busy2, data_valid2, par_err2, stp_err2, strt_glitch2;
  logic [1:0] err_cnt2;

  int edge_cnt, bit_cnt;
  int n_vec = 0, n_err = 0;
  int exp_cnt8 = 0, exp_cnt2 = 0;
  int deser_cyc, dv_cnt, gl_cnt;

  uart_rx_ctrl #(.ERR_CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .edge_cnt_done(edge_cnt_done), .bit_cnt_done(bit_cnt_done), .sampled_bit(sampled_bit),
    .counter_en(counter_en), .deser_en(deser_en), .busy(busy), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err), .strt_glitch(strt_glitch), .err_cnt(err_cnt)
  );

  uart_rx_ctrl #(.ERR_CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .edge_cnt_done(edge_cnt_done), .bit_cnt_done(bit_cnt_done), .sampled_bit(sampled_bit),
    .counter_en(counter_en2), .deser_en(deser_en2), .busy(busy2), .data_valid(data_valid2),
    .par_err(par_err2), .stp_err(stp_err2), .strt_glitch(strt_glitch2), .err_cnt(err_cnt2)
  );

  always #5 CLK = ~CLK;

  // Ideal oversampling counter and bit counter surrounding the controller
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= 0;
      bit_cnt  <= 0;
    end else begin
      if (!counter_en || edge_cnt == P - 1) edge_cnt <= 0;
      else edge_cnt <= edge_cnt + 1;
      if (!deser_en) bit_cnt <= 0;
      else if (edge_cnt_done) bit_cnt <= bit_cnt + 1;
    end
  end

  assign edge_cnt_done = counter_en && (edge_cnt == P - 1);
  assign bit_cnt_done  = (bit_cnt == 7);
  assign sampled_bit   = RX_IN;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (deser_en) deser_cyc++;
      if (data_valid) dv_cnt++;
      if (strt_glitch) gl_cnt++;
    end
  endtask

  task automatic check_counts();
    check("err_cnt", 32'(err_cnt), 32'(exp_cnt8));
    check("err_cnt_w2", 32'(err_cnt2), 32'(exp_cnt2));
  endtask

  // abort_bit >= 0 pulls reset in the middle of that data bit
  task automatic send_frame(input logic [7:0] b, input bit pe, input bit pt, input bit par_bad,
                            input bit stop_b, input bit toggle, input int abort_bit);
    bit exp_pe, exp_se, exp_dv;
    PAR_EN = pe;
    PAR_TYP = pt;
    deser_cyc = 0; dv_cnt = 0; gl_cnt = 0;
    @(negedge CLK);
    RX_IN = 1'b0;
    tick(1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_clr", 32'({par_err, stp_err}), 32'd0);
    if (toggle) begin PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); end
    tick(P);
    for (int k = 0; k < 8; k++) begin
      RX_IN = b[k];
      if (k == abort_bit) begin
        tick(P / 2);
        #2 RST = 1'b0;
        #1;
        check("rst_outs", 32'({counter_en, deser_en, busy, data_valid, par_err, stp_err,
                                strt_glitch}), 32'd0);
        exp_cnt8 = 0;
        exp_cnt2 = 0;
        check_counts();
        @(negedge CLK);
        RX_IN = 1'b1;
        RST = 1'b1;
        tick(5);
        check("rst_idle", 32'(busy), 32'd0);
        return;
      end
      tick(P);
      if (toggle) begin PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); end
    end
    if (pe) begin
      RX_IN = (^b) ^ pt ^ par_bad;
      tick(P);
    end
    RX_IN = stop_b;
    tick(P - 1);
    check("stop_busy", 32'(busy), 32'd1);
    tick(1);
    RX_IN = 1'b1;
    exp_pe = pe && par_bad;
    exp_se = !stop_b;
    exp_dv = !exp_pe && !exp_se;
    if (!exp_dv) begin
      if (exp_cnt8 < 255) exp_cnt8++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
    check("dv", 32'(data_valid), 32'(exp_dv));
    check("par_err", 32'(par_err), 32'(exp_pe));
    check("stp_err", 32'(stp_err), 32'(exp_se));
    check("end_idle", 32'(busy), 32'd0);
    check("deser_cyc", 32'(deser_cyc), 32'(8 * P));
    check_counts();
    tick(1);
    check("dv_pulse", 32'(dv_cnt), 32'(exp_dv));
    check("flags_held", 32'({par_err, stp_err}), 32'({exp_pe, exp_se}));
    check("no_glitch", 32'(gl_cnt), 32'd0);
  endtask

  task automatic send_glitch();
    deser_cyc = 0; dv_cnt = 0; gl_cnt = 0;
    @(negedge CLK);
    RX_IN = 1'b0;
    tick(2);
    RX_IN = 1'b1;
    tick(P - 1);
    check("glitch", 32'(strt_glitch), 32'd1);
    check("glitch_idle", 32'(busy), 32'd0);
    check_counts();
    tick(1);
    check("glitch_pulse", 32'(gl_cnt), 32'd1);
    check("glitch_deser", 32'(deser_cyc), 32'd0);
  endtask

  initial begin
    #12;
    check("rst_outs0", 32'({counter_en, deser_en, busy, data_valid, par_err, stp_err,
                            strt_glitch}), 32'd0);
    check_counts();
    @(negedge CLK);
    RST = 1'b1;
    tick(3);
    check("idle_hold", 32'(busy), 32'd0);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    send_glitch();
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    for (int i = 0; i < 5; i++) begin
      send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1, -1);
    end

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(7) == 0) begin
        send_glitch();
      end else begin
        send_frame(8'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(2) == 0),
                   ($urandom_range(3) != 0), 1'($urandom), -1);
      end
      if ($urandom_range(1) == 0) tick($urandom_range(4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Frame-sequencing controller for the UART receiver. Detects the start-bit falling edge and drives the enables of the edge/bit counter and deserializer. Checks start glitch, parity and stop bit from the majority-voted sampled bit, and reports a validated byte or error flags per frame. Sits between the RX pin, the oversampling edge/bit counter, the data sampler and the deserializer.

## Interface
- ERR_CNT_W, 8: width of the saturating errored-frame counter.

- CLK  input  1  receiver clock (oversampling clock, Prescale × baud).
- RST  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line, idle high.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even, 1 = odd parity.
- edge_cnt_done  input  1  last oversampling edge of current bit (edge_cnt == Prescale-1).
- bit_cnt_done  input  1  bit counter at 7 (eighth data bit).
- sampled_bit  input  1  voted bit value; valid on every edge_cnt_done cycle.
- counter_en  output  1  enables edge/bit counting.
- deser_en  output  1  data-bit phase; gates bit counter increment and deserializer shift.
- busy  output  1  frame in progress (state ≠ IDLE).
- data_valid  output  1  one-cycle pulse: error-free byte ready in deserializer.
- par_err  output  1  parity mismatch on last frame, held.
- stp_err  output  1  stop bit sampled 0 on last frame, held.
- strt_glitch  output  1  one-cycle pulse: start bit sampled 1.
- err_cnt  output  ERR_CNT_W  saturating count of frames with par_err or stp_err.

## Operation
- States: IDLE, START, DATA, PARITY, STOP (3-bit encoded).
- counter_en = busy = (state ≠ IDLE); deser_en = (state == DATA). Both are decoded from the state register only.
- IDLE: RX_IN == 0 → START. On this transition, latch PAR_EN/PAR_TYP into frame registers, clear the parity accumulator, and clear par_err and stp_err. Mid-frame changes to PAR_EN/PAR_TYP are ignored.
- START, on edge_cnt_done: sampled_bit == 1 → pulse strt_glitch and go to IDLE. Otherwise go to DATA.
- DATA, on edge_cnt_done: accumulator ^= sampled_bit. If bit_cnt_done, go to PARITY when latched PAR_EN = 1, else to STOP.
- PARITY, on edge_cnt_done: expected = accumulator ^ latched PAR_TYP. Set par_err = (sampled_bit ≠ expected). Go to STOP.
- STOP, on edge_cnt_done: set stp_err = ~sampled_bit, then go to IDLE.
  - If the frame has no errors (new par_err and stp_err both 0), pulse data_valid.
  - Otherwise increment err_cnt; it saturates at all-ones.
  - A frame with both errors sets both flags and counts once.
- edge_cnt_done outside non-IDLE states is ignored. Start glitches are not counted in err_cnt.
- RST low at any time forces IDLE and clears all outputs and internal registers immediately. Counting resumes only after a fresh falling edge.

## Timing
- Reset values:
  - counter_en, deser_en, busy, data_valid, par_err, stp_err, strt_glitch: 0.
  - err_cnt: 0.
- State, pulses and flags are registered, updating on the CLK edge after the qualifying cycle.
- Let t = the cycle RX_IN is sampled 0 in IDLE, and P = Prescale.
  - START occupies cycles t+1 .. t+P.
  - Each subsequent bit occupies P cycles.
  - The counter restarts at 0 each bit.
- The edge_cnt_done of the last data bit (bit_cnt_done = 1) occurs at t+9P.
- With parity: STOP done at t+11P; data_valid, err flags and IDLE at t+11P+1.
- Without parity: STOP done at t+10P; data_valid, err flags and IDLE at t+10P+1.
- Start glitch: strt_glitch high and state IDLE at t+P+1. deser_en is never asserted.
- Back-to-back frames: RX_IN == 0 in the first IDLE cycle starts the next frame, i.e. one idle cycle minimum between frames.

## Test plan
- P=8, PAR_EN=1, PAR_TYP=0, byte 0xA5 LSB first, parity 0, stop 1 → deser_en high for 64 cycles, data_valid pulse at t+89, par_err=stp_err=0, err_cnt=0.
- Same frame, parity bit 1 → par_err=1 at t+89 and held, data_valid stays 0, err_cnt=1. The next good frame clears par_err at its START entry.
- PAR_EN=0, byte 0x3C, stop bit 0 → stp_err=1 at t+81, no data_valid, err_cnt increments by 1.
- RX_IN low 2 cycles then high (sampled_bit=1 at START done) → strt_glitch one-cycle pulse at t+9, busy=0 at t+9, err_cnt unchanged.
- Assert RST low mid-DATA (bit 4) → all outputs 0 asynchronously. After release, RX_IN high keeps IDLE, and the next full frame is received correctly.
- ERR_CNT_W=2, five consecutive stop-error frames → err_cnt sequence 1,2,3,3,3. Toggling PAR_EN mid-frame does not change that frame's parity handling.
